// File: rtl/busy_table_ckpt.sv
// Physical-register busy table with same-cycle clear bypass and checkpoint slots.
// Checkpoint slots keep receiving writeback clears so that a restore recovers the current state.
module busy_table_ckpt #(
  parameter int PRF_NUM   = 64,
  parameter int RD_PORTS  = 4,
  parameter int SET_PORTS = 2,
  parameter int CLR_PORTS = 4,
  parameter int CKPT_NUM  = 4,
  localparam int PW = $clog2(PRF_NUM),
  localparam int CW = $clog2(CKPT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [RD_PORTS*PW-1:0]    rd_num,
  output logic [RD_PORTS-1:0]       busy,
  input  logic [SET_PORTS-1:0]      set_valid,
  input  logic [SET_PORTS*PW-1:0]   set_num,
  input  logic [CLR_PORTS-1:0]      clr_valid,
  input  logic [CLR_PORTS*PW-1:0]   clr_num,
  input  logic                      ckpt_save,
  input  logic [CW-1:0]             ckpt_save_id,
  input  logic                      ckpt_restore,
  input  logic [CW-1:0]             ckpt_restore_id,
  input  logic                      ckpt_free,
  input  logic [CW-1:0]             ckpt_free_id,
  output logic [CKPT_NUM-1:0]       ckpt_valid,
  output logic                      ckpt_err
);

  logic [PRF_NUM-1:0]  t_q, t_d;
  logic [PRF_NUM-1:0]  s_q [CKPT_NUM];
  logic [PRF_NUM-1:0]  s_d [CKPT_NUM];
  logic [CKPT_NUM-1:0] v_q, v_d;
  logic                err_q, err_d;
  logic [PRF_NUM-1:0]  setv, clrv, t_norm;
  logic                restore_ok;

  // PRF 0 is the hardwired zero register and can never become busy.
  always_comb begin
    setv = '0;
    clrv = '0;
    for (int j = 0; j < SET_PORTS; j++)
      if (set_valid[j]) setv[set_num[j*PW +: PW]] = 1'b1;
    for (int j = 0; j < CLR_PORTS; j++)
      if (clr_valid[j]) clrv[clr_num[j*PW +: PW]] = 1'b1;
    setv[0] = 1'b0;
  end

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [PW-1:0] num;
      assign num      = rd_num[gi*PW +: PW];
      assign busy[gi] = (num != '0) & t_q[num] & ~clrv[num];
    end
  endgenerate

  assign t_norm     = (t_q & ~clrv) | setv;
  assign restore_ok = ckpt_restore & v_q[ckpt_restore_id];

  always_comb begin
    t_d   = t_norm;
    v_d   = v_q;
    err_d = 1'b0;
    for (int k = 0; k < CKPT_NUM; k++)
      s_d[k] = v_q[k] ? (s_q[k] & ~clrv) : s_q[k];
    if (flush) begin
      t_d = '0;
      v_d = '0;
    end else if (restore_ok) begin
      t_d                  = s_q[ckpt_restore_id] & ~clrv;
      v_d[ckpt_restore_id] = 1'b0;
    end else begin
      // Reaching here with a restore request means the slot was empty.
      err_d = ckpt_restore;
      if (ckpt_free) v_d[ckpt_free_id] = 1'b0;
      if (ckpt_save) begin
        s_d[ckpt_save_id] = t_norm;
        v_d[ckpt_save_id] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q   <= '0;
      v_q   <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < CKPT_NUM; k++) s_q[k] <= '0;
    end else begin
      t_q   <= t_d;
      v_q   <= v_d;
      err_q <= err_d;
      for (int k = 0; k < CKPT_NUM; k++) s_q[k] <= s_d[k];
    end
  end

  assign ckpt_valid = v_q;
  assign ckpt_err   = err_q;

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Scoreboard bench: a default-size instance for directed scenarios and a wide instance
// (128 PRFs, 8 slots) for random traffic, both checked against a behavioural model.
module tb_busy_table_ckpt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  // default instance (ctx 0)
  logic [23:0] rd_num0;  logic [3:0] busy0;
  logic [1:0]  set_valid0; logic [11:0] set_num0;
  logic [3:0]  clr_valid0; logic [23:0] clr_num0;
  logic save0, rest0, free0; logic [1:0] sid0, rid0, fid0;
  logic [3:0]  ckpt_valid0; logic err0;
  // wide instance (ctx 1)
  logic [41:0] rd_num1;  logic [5:0] busy1;
  logic [3:0]  set_valid1; logic [27:0] set_num1;
  logic [5:0]  clr_valid1; logic [41:0] clr_num1;
  logic save1, rest1, free1; logic [2:0] sid1, rid1, fid1;
  logic [7:0]  ckpt_valid1; logic err1;

  busy_table_ckpt dut (
    .clk(clk), .rst(rst), .flush(flush), .rd_num(rd_num0), .busy(busy0),
    .set_valid(set_valid0), .set_num(set_num0), .clr_valid(clr_valid0), .clr_num(clr_num0),
    .ckpt_save(save0), .ckpt_save_id(sid0), .ckpt_restore(rest0), .ckpt_restore_id(rid0),
    .ckpt_free(free0), .ckpt_free_id(fid0), .ckpt_valid(ckpt_valid0), .ckpt_err(err0));

  busy_table_ckpt #(.PRF_NUM(128), .RD_PORTS(6), .SET_PORTS(4), .CLR_PORTS(6), .CKPT_NUM(8)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .rd_num(rd_num1), .busy(busy1),
    .set_valid(set_valid1), .set_num(set_num1), .clr_valid(clr_valid1), .clr_num(clr_num1),
    .ckpt_save(save1), .ckpt_save_id(sid1), .ckpt_restore(rest1), .ckpt_restore_id(rid1),
    .ckpt_free(free1), .ckpt_free_id(fid1), .ckpt_valid(ckpt_valid1), .ckpt_err(err1));

  int errors = 0;
  int checks = 0;

  // stimulus for the next cycle
  int st_rd[6]; bit st_sv[4]; int st_sn[4]; bit st_cv[6]; int st_cn[6];
  bit st_save, st_rest, st_free, st_flush, st_rst;
  int st_sid, st_rid, st_fid;

  // behavioural model, one context per instance
  logic [127:0] mt [2];
  logic [127:0] ms [2][8];
  logic [7:0]   mv [2];
  logic         merr [2];

  logic [5:0] q_busy[$];
  logic [8:0] q_reg[$];
  logic [5:0] obs_busy;
  logic [7:0] obs_valid;
  logic       obs_err;

  function automatic int n_rd(int c);  return c ? 6 : 4;     endfunction
  function automatic int n_set(int c); return c ? 4 : 2;     endfunction
  function automatic int n_clr(int c); return c ? 6 : 4;     endfunction
  function automatic int n_prf(int c); return c ? 128 : 64;  endfunction
  function automatic int n_ck(int c);  return c ? 8 : 4;     endfunction

  task automatic clear_stim();
    for (int i = 0; i < 6; i++) begin st_rd[i] = 0; st_cv[i] = 0; st_cn[i] = 0; end
    for (int i = 0; i < 4; i++) begin st_sv[i] = 0; st_sn[i] = 0; end
    st_save = 0; st_rest = 0; st_free = 0; st_flush = 0; st_rst = 0;
    st_sid = 0; st_rid = 0; st_fid = 0;
  endtask

  function automatic logic [127:0] f_setv(int c, bit act);
    logic [127:0] v = '0;
    if (act) for (int j = 0; j < n_set(c); j++) if (st_sv[j]) v[st_sn[j]] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

  function automatic logic [127:0] f_clrv(int c, bit act);
    logic [127:0] v = '0;
    if (act) for (int j = 0; j < n_clr(c); j++) if (st_cv[j]) v[st_cn[j]] = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] f_busy(int c);
    logic [127:0] cv = f_clrv(c, 1'b1);
    logic [5:0] r = '0;
    for (int i = 0; i < n_rd(c); i++)
      if (st_rd[i] != 0 && mt[c][st_rd[i]] && !cv[st_rd[i]]) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input int c, input bit act);
    logic [127:0] sv, cv, tn;
    bit rok;
    sv = f_setv(c, act);
    cv = f_clrv(c, act);
    if (st_rst) begin
      mt[c] = '0; mv[c] = '0; merr[c] = 1'b0;
      for (int k = 0; k < 8; k++) ms[c][k] = '0;
    end else if (st_flush) begin
      mt[c] = '0; mv[c] = '0; merr[c] = 1'b0;
    end else begin
      rok     = act && st_rest && mv[c][st_rid];
      merr[c] = act && st_rest && !mv[c][st_rid];
      for (int k = 0; k < n_ck(c); k++) if (mv[c][k]) ms[c][k] = ms[c][k] & ~cv;
      if (rok) begin
        mt[c] = ms[c][st_rid];
        mv[c][st_rid] = 1'b0;
      end else begin
        tn = (mt[c] & ~cv) | sv;
        mt[c] = tn;
        if (act && st_free) mv[c][st_fid] = 1'b0;
        if (act && st_save) begin ms[c][st_sid] = tn; mv[c][st_sid] = 1'b1; end
      end
    end
  endtask

  task automatic drive_ports(input int c);
    rst = st_rst; flush = st_flush;
    rd_num0 = '0; set_valid0 = '0; set_num0 = '0; clr_valid0 = '0; clr_num0 = '0;
    save0 = 0; rest0 = 0; free0 = 0; sid0 = '0; rid0 = '0; fid0 = '0;
    rd_num1 = '0; set_valid1 = '0; set_num1 = '0; clr_valid1 = '0; clr_num1 = '0;
    save1 = 0; rest1 = 0; free1 = 0; sid1 = '0; rid1 = '0; fid1 = '0;
    if (c == 0) begin
      for (int i = 0; i < 4; i++) rd_num0[i*6 +: 6] = 6'(st_rd[i]);
      for (int i = 0; i < 2; i++) begin set_valid0[i] = st_sv[i]; set_num0[i*6 +: 6] = 6'(st_sn[i]); end
      for (int i = 0; i < 4; i++) begin clr_valid0[i] = st_cv[i]; clr_num0[i*6 +: 6] = 6'(st_cn[i]); end
      save0 = st_save; sid0 = 2'(st_sid); rest0 = st_rest; rid0 = 2'(st_rid);
      free0 = st_free; fid0 = 2'(st_fid);
    end else begin
      for (int i = 0; i < 6; i++) rd_num1[i*7 +: 7] = 7'(st_rd[i]);
      for (int i = 0; i < 4; i++) begin set_valid1[i] = st_sv[i]; set_num1[i*7 +: 7] = 7'(st_sn[i]); end
      for (int i = 0; i < 6; i++) begin clr_valid1[i] = st_cv[i]; clr_num1[i*7 +: 7] = 7'(st_cn[i]); end
      save1 = st_save; sid1 = 3'(st_sid); rest1 = st_rest; rid1 = 3'(st_rid);
      free1 = st_free; fid1 = 3'(st_fid);
    end
  endtask

  // One clock cycle on context c: expectations are queued as stimulus is applied,
  // busy is popped mid-cycle and registered outputs are popped after the edge.
  task automatic cycle(input int c);
    logic [5:0] ab, eb;
    logic [8:0] ar, er;
    drive_ports(c);
    q_busy.push_back(f_busy(c));
    model_step(0, c == 0);
    model_step(1, c == 1);
    q_reg.push_back({mv[c], merr[c]});
    @(negedge clk);
    ab = (c != 0) ? busy1 : {2'b00, busy0};
    eb = q_busy.pop_front();
    checks++;
    if (ab !== eb) begin
      errors++;
      $display("FAIL busy ctx%0d @%0t: got %b expected %b", c, $time, ab, eb);
    end
    obs_busy = ab;
    @(posedge clk);
    #1;
    ar = (c != 0) ? {ckpt_valid1, err1} : {4'b0000, ckpt_valid0, err0};
    er = q_reg.pop_front();
    checks++;
    if (ar !== er) begin
      errors++;
      $display("FAIL ckpt_state ctx%0d @%0t: got valid=%b err=%b expected valid=%b err=%b",
               c, $time, ar[8:1], ar[0], er[8:1], er[0]);
    end
    obs_valid = ar[8:1];
    obs_err   = ar[0];
    $display("txn ctx=%0d t=%0t busy=%b ckpt_valid=%b ckpt_err=%b", c, $time, ab, obs_valid, obs_err);
    clear_stim();
  endtask

  task automatic test_reset();
    st_rd[0] = 5; st_rd[1] = 63; st_rd[2] = 1; st_rd[3] = 0;
    cycle(0);
    checks++;
    if (obs_busy !== 6'd0 || obs_valid !== 8'd0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b err=%b expected all zero", obs_busy, obs_valid, obs_err);
    end
  endtask

  task automatic test_set_bypass();
    st_sv[0] = 1; st_sn[0] = 5; st_rd[0] = 5; cycle(0);
    checks++;
    if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL set_same_cycle: busy=%b expected 0", obs_busy[0]); end
    st_rd[0] = 5; cycle(0);
    checks++;
    if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL set_next_cycle: busy=%b expected 1", obs_busy[0]); end
    st_cv[2] = 1; st_cn[2] = 5; st_rd[0] = 5; cycle(0);
    checks++;
    if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL clear_bypass: busy=%b expected 0", obs_busy[0]); end
    st_rd[3] = 5; cycle(0);
    checks++;
    if (obs_busy[3] !== 1'b0) begin errors++; $display("FAIL clear_done: busy=%b expected 0", obs_busy[3]); end
  endtask

  task automatic test_conflict();
    st_sv[1] = 1; st_sn[1] = 7; st_cv[0] = 1; st_cn[0] = 7;
    st_sv[0] = 1; st_sn[0] = 0;
    st_rd[0] = 7; cycle(0);
    st_rd[0] = 7; st_rd[1] = 0; cycle(0);
    checks++;
    if (obs_busy[1:0] !== 2'b01) begin
      errors++; $display("FAIL set_wins_and_prf0: busy[1:0]=%b expected 01", obs_busy[1:0]);
    end
    // duplicate set and duplicate clear numbers across ports
    st_sv[0] = 1; st_sn[0] = 8; st_sv[1] = 1; st_sn[1] = 8; cycle(0);
    st_cv[0] = 1; st_cn[0] = 8; st_cv[3] = 1; st_cn[3] = 8; st_rd[2] = 8; cycle(0);
    st_rd[2] = 8; st_rd[3] = 7; cycle(0);
    checks++;
    if (obs_busy[3:2] !== 2'b10) begin
      errors++; $display("FAIL duplicate_ports: busy[3:2]=%b expected 10", obs_busy[3:2]);
    end
  endtask

  task automatic test_snapshot();
    st_sv[0] = 1; st_sn[0] = 3; st_sv[1] = 1; st_sn[1] = 9; st_cv[0] = 1; st_cn[0] = 7; cycle(0);
    st_sv[0] = 1; st_sn[0] = 12; st_save = 1; st_sid = 1; cycle(0);
    checks++;
    if (obs_valid[1] !== 1'b1) begin errors++; $display("FAIL save_valid: valid[1]=%b expected 1", obs_valid[1]); end
    st_sv[0] = 1; st_sn[0] = 20; cycle(0);
    st_cv[1] = 1; st_cn[1] = 9; cycle(0);
    // restore; the set and save in this cycle must be ignored
    st_rest = 1; st_rid = 1; st_sv[0] = 1; st_sn[0] = 30; st_save = 1; st_sid = 2;
    st_rd[0] = 3; st_rd[1] = 12; st_rd[2] = 9; st_rd[3] = 20; cycle(0);
    checks++;
    if (obs_busy[3:0] !== 4'b1011 || obs_valid[2:1] !== 2'b00) begin
      errors++; $display("FAIL restore_cycle: busy=%b valid=%b expected busy 1011 valid[2:1] 00", obs_busy[3:0], obs_valid);
    end
    st_rd[0] = 3; st_rd[1] = 12; st_rd[2] = 9; st_rd[3] = 20; cycle(0);
    checks++;
    if (obs_busy[3:0] !== 4'b0011) begin
      errors++; $display("FAIL restored_table: busy=%b expected 0011", obs_busy[3:0]);
    end
    st_rd[0] = 30; cycle(0);
    checks++;
    if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL restore_ignores_set: busy=%b expected 0", obs_busy[0]); end
  endtask

  task automatic test_invalid_restore();
    st_rest = 1; st_rid = 2; st_sv[0] = 1; st_sn[0] = 40; cycle(0);
    checks++;
    if (obs_err !== 1'b1) begin errors++; $display("FAIL invalid_restore_err: err=%b expected 1", obs_err); end
    st_rd[0] = 40; st_rd[1] = 3; cycle(0);
    checks++;
    if (obs_err !== 1'b0 || obs_busy[1:0] !== 2'b11) begin
      errors++; $display("FAIL invalid_restore_after: err=%b busy=%b expected err 0 busy 11", obs_err, obs_busy[1:0]);
    end
    // save and free to the same slot: save wins; then a free, then a free of an empty slot
    st_save = 1; st_sid = 3; st_free = 1; st_fid = 3; cycle(0);
    checks++;
    if (obs_valid[3] !== 1'b1) begin errors++; $display("FAIL save_beats_free: valid[3]=%b expected 1", obs_valid[3]); end
    st_free = 1; st_fid = 3; cycle(0);
    st_free = 1; st_fid = 0; cycle(0);
    checks++;
    if (obs_valid[3:0] !== 4'b0000 || obs_err !== 1'b0) begin
      errors++; $display("FAIL free_slots: valid=%b err=%b expected 0000 0", obs_valid[3:0], obs_err);
    end
  endtask

  task automatic build_busy_state();
    for (int n = 0; n < 5; n++) begin
      st_sv[0] = 1; st_sn[0] = 10 + 2*n; st_sv[1] = 1; st_sn[1] = 11 + 2*n;
      if (n < 3) begin st_save = 1; st_sid = n; end
      cycle(0);
    end
    checks++;
    if (obs_valid[3:0] !== 4'b0111) begin errors++; $display("FAIL setup_slots: valid=%b expected 0111", obs_valid[3:0]); end
  endtask

  task automatic check_all_clear(input string tag);
    for (int b = 10; b < 20; b += 4) begin
      for (int i = 0; i < 4; i++) st_rd[i] = (b + i < 20) ? b + i : 0;
      cycle(0);
      checks++;
      if (obs_busy !== 6'd0 || obs_valid !== 8'd0) begin
        errors++; $display("FAIL %s_clear: busy=%b valid=%b expected zero", tag, obs_busy, obs_valid);
      end
    end
  endtask

  task automatic test_flush_and_reset();
    build_busy_state();
    st_flush = 1; st_rest = 1; st_rid = 0; cycle(0);
    check_all_clear("flush");
    build_busy_state();
    st_rst = 1; st_rest = 1; st_rid = 1; st_save = 1; st_sid = 3; cycle(0);
    check_all_clear("reset");
  endtask

  task automatic rand_stim(input int c);
    int np;
    np = n_prf(c);
    for (int i = 0; i < 6; i++) st_rd[i] = ($urandom_range(1) == 1) ? $urandom_range(15) : $urandom_range(np - 1);
    for (int j = 0; j < 4; j++) begin
      st_sv[j] = ($urandom_range(1) == 1);
      st_sn[j] = ($urandom_range(1) == 1) ? $urandom_range(15) : $urandom_range(np - 1);
    end
    for (int j = 0; j < 6; j++) begin
      st_cv[j] = ($urandom_range(3) == 0);
      st_cn[j] = ($urandom_range(1) == 1) ? $urandom_range(15) : $urandom_range(np - 1);
    end
    st_save = ($urandom_range(5) == 0); st_sid = $urandom_range(n_ck(c) - 1);
    st_rest = ($urandom_range(5) == 0); st_rid = $urandom_range(n_ck(c) - 1);
    st_free = ($urandom_range(7) == 0); st_fid = $urandom_range(n_ck(c) - 1);
    st_flush = ($urandom_range(99) == 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin rand_stim(0); cycle(0); end
  endtask

  task automatic test_param_sweep();
    for (int n = 0; n < 1500; n++) begin rand_stim(1); cycle(1); end
  endtask

  initial begin
    clear_stim();
    for (int c = 0; c < 2; c++) begin
      mt[c] = '0; mv[c] = '0; merr[c] = 1'b0;
      for (int k = 0; k < 8; k++) ms[c][k] = '0;
    end
    drive_ports(0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_set_bypass();
    test_conflict();
    test_snapshot();
    test_invalid_restore();
    test_flush_and_reset();
    test_back_to_back();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
